alu_sequencer: RTL and testbench

Multicycle operand-staging and write-back sequencer that sits directly upstream of the ALU in the datapath. It owns an 8-entry register file, accepts one command at a time over a valid/ready handshake, and stages operands into A and B registers (B passes through an optional shifter). It drives `ain`/`bin`/`ALUop` into the ALU, captures `alu_out` into the C register and `status_in` into a Z flag, then writes C back to the destination register.

---
 rtl/alu_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Operand-staging and write-back sequencer for a combinational
//               ALU. It owns an 8-entry register file, stages A and B, captures
//               C and Z, and writes C back. Defining ALU_SEQ_SHIFTER_EN adds
//               the B-operand shifter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
    parameter int M = 16,
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_imm,
    input  logic [N-1:0] cmd_op,
    input  logic [2:0]   cmd_rd,
    input  logic [2:0]   cmd_rn,
    input  logic [2:0]   cmd_rm,
    input  logic [1:0]   cmd_shift,
    input  logic         cmd_asel,
    input  logic         cmd_wb,
    input  logic [M-1:0] cmd_data,
    output logic [M-1:0] ain,
    output logic [M-1:0] bin,
    output logic [N-1:0] ALUop,
    input  logic [M-1:0] alu_out,
    input  logic         status_in,
    output logic [M-1:0] result,
    output logic         status_z,
    output logic         done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LDA  = 3'd1,
        S_LDB  = 3'd2,
        S_EXEC = 3'd3,
        S_WB   = 3'd4
    } state_t;

    state_t       state_q;
    logic [M-1:0] rf_q [8];
    logic [M-1:0] a_q;
    logic [M-1:0] b_q;
    logic [M-1:0] c_q;
    logic         z_q;
    logic [N-1:0] op_q;
    logic         done_q;
    logic [2:0]   rd_q;
    logic [2:0]   rn_q;
    logic [2:0]   rm_q;
    logic         asel_q;
    logic         wb_q;
    logic [M-1:0] b_d;

`ifdef ALU_SEQ_SHIFTER_EN
    logic [1:0]   shift_q;

    always_comb begin
        b_d = rf_q[rm_q];
        case (shift_q)
            2'b01:   b_d = {rf_q[rm_q][M-2:0], 1'b0};
            2'b10:   b_d = {1'b0, rf_q[rm_q][M-1:1]};
            2'b11:   b_d = {rf_q[rm_q][M-1], rf_q[rm_q][M-1:1]};
            default: b_d = rf_q[rm_q];
        endcase
    end
`else
    logic unused_shift;

    assign unused_shift = ^cmd_shift;
    assign b_d          = rf_q[rm_q];
`endif

    // Ready drops combinationally with reset so nothing is offered mid-reset.
    assign cmd_ready = reset_n && (state_q == S_IDLE);
    assign ain       = a_q;
    assign bin       = b_q;
    assign ALUop     = op_q;
    assign result    = c_q;
    assign status_z  = z_q;
    assign done      = done_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            rf_q    <= '{default: '0};
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            z_q     <= 1'b0;
            op_q    <= '0;
            done_q  <= 1'b0;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            asel_q  <= 1'b0;
            wb_q    <= 1'b0;
`ifdef ALU_SEQ_SHIFTER_EN
            shift_q <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        if (cmd_imm) begin
                            rf_q[cmd_rd] <= cmd_data;
                            done_q       <= 1'b1;
                        end else begin
                            op_q    <= cmd_op;
                            rd_q    <= cmd_rd;
                            rn_q    <= cmd_rn;
                            rm_q    <= cmd_rm;
                            asel_q  <= cmd_asel;
                            wb_q    <= cmd_wb;
`ifdef ALU_SEQ_SHIFTER_EN
                            shift_q <= cmd_shift;
`endif
                            state_q <= S_LDA;
                        end
                    end
                end
                S_LDA: begin
                    a_q     <= asel_q ? '0 : rf_q[rn_q];
                    state_q <= S_LDB;
                end
                S_LDB: begin
                    b_q     <= b_d;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    c_q     <= alu_out;
                    z_q     <= status_in;
                    state_q <= S_WB;
                end
                S_WB: begin
                    if (wb_q) begin
                        rf_q[rd_q] <= c_q;
                    end
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Directed self-checking bench for alu_sequencer with a small
//               combinational ALU model (00 add, 01 sub, 10 and, 11 pass A).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_imm = 1'b0;
    logic [1:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_rn = '0;
    logic [2:0]  cmd_rm = '0;
    logic [1:0]  cmd_shift = '0;
    logic        cmd_asel = 1'b0;
    logic        cmd_wb = 1'b0;
    logic [15:0] cmd_data = '0;
    logic [15:0] ain;
    logic [15:0] bin;
    logic [1:0]  ALUop;
    logic [15:0] alu_out;
    logic        status_in;
    logic [15:0] result;
    logic        status_z;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    alu_sequencer #(.M(16), .N(2)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_imm   (cmd_imm),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rn    (cmd_rn),
        .cmd_rm    (cmd_rm),
        .cmd_shift (cmd_shift),
        .cmd_asel  (cmd_asel),
        .cmd_wb    (cmd_wb),
        .cmd_data  (cmd_data),
        .ain       (ain),
        .bin       (bin),
        .ALUop     (ALUop),
        .alu_out   (alu_out),
        .status_in (status_in),
        .result    (result),
        .status_z  (status_z),
        .done      (done)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (ALUop)
            2'd0:    alu_out = ain + bin;
            2'd1:    alu_out = ain - bin;
            2'd2:    alu_out = ain & bin;
            default: alu_out = ain;
        endcase
        status_in = (alu_out == 16'h0000);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_imm(input logic [2:0] rd, input logic [15:0] val, input string tag);
        @(negedge clk);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_imm   = 1'b1;
        cmd_rd    = rd;
        cmd_data  = val;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_imm   = 1'b0;
        cmd_data  = ~val;
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
    endtask

    // Returns at #1 after the edge that raises done; fields are scrambled after
    // accept so a design that fails to latch them shows up.
    task automatic run_alu(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rn,
                           input logic [2:0] rm, input logic [1:0] sh, input logic asel,
                           input logic wb, input string tag);
        int lat;
        @(negedge clk);
        check_eq({tag, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        cmd_imm   = 1'b0;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rn    = rn;
        cmd_rm    = rm;
        cmd_shift = sh;
        cmd_asel  = asel;
        cmd_wb    = wb;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = ~op;
        cmd_rd    = ~rd;
        cmd_rn    = ~rn;
        cmd_rm    = ~rm;
        cmd_shift = ~sh;
        cmd_asel  = ~asel;
        cmd_wb    = ~wb;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, "_lat"}, lat, 32'd4);
    endtask

    task automatic read_reg(input logic [2:0] idx, input logic [15:0] exp, input string tag);
        run_alu(2'd3, 3'd0, idx, 3'd0, 2'd0, 1'b0, 1'b0, tag);
        check_eq({tag, "_val"}, {16'd0, result}, {16'd0, exp});
    endtask

    initial begin
        logic [15:0] sh_exp [4];
        int          accepts;
        int          done_seen;

`ifdef ALU_SEQ_SHIFTER_EN
        sh_exp[0] = 16'h8001;
        sh_exp[1] = 16'h0002;
        sh_exp[2] = 16'h4000;
        sh_exp[3] = 16'hC000;
`else
        sh_exp[0] = 16'h8001;
        sh_exp[1] = 16'h8001;
        sh_exp[2] = 16'h8001;
        sh_exp[3] = 16'h8001;
`endif

        // Reset
        #3 reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ain", {16'd0, ain}, 32'd0);
        check_eq("rst_bin", {16'd0, bin}, 32'd0);
        check_eq("rst_result", {16'd0, result}, 32'd0);
        check_eq("rst_z", {31'd0, status_z}, 32'd0);
        reset_n = 1'b1;
        #1;
        check_eq("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

        // Immediates and basic ADD with write-back
        load_imm(3'd0, 16'd5, "imm_r0");
        load_imm(3'd1, 16'd3, "imm_r1");
        run_alu(2'd0, 3'd2, 3'd0, 3'd1, 2'b00, 1'b0, 1'b1, "add");
        check_eq("add_result", {16'd0, result}, 32'd8);
        check_eq("add_z", {31'd0, status_z}, 32'd0);
        check_eq("add_ain", {16'd0, ain}, 32'd5);
        check_eq("add_bin", {16'd0, bin}, 32'd3);
        check_eq("add_ready", {31'd0, cmd_ready}, 32'd1);
        read_reg(3'd2, 16'd8, "rd_r2");

        // SUB to zero without write-back
        run_alu(2'd1, 3'd3, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, "sub");
        check_eq("sub_result", {16'd0, result}, 32'd0);
        check_eq("sub_z", {31'd0, status_z}, 32'd1);
        load_imm(3'd7, 16'h1234, "imm_r7");
        check_eq("imm_keeps_z", {31'd0, status_z}, 32'd1);
        read_reg(3'd3, 16'd0, "rd_r3");

        // B-operand shifter with A forced to zero
        load_imm(3'd4, 16'h8001, "imm_r4");
        for (int s = 0; s < 4; s++) begin
            run_alu(2'd0, 3'd6, 3'd1, 3'd4, s[1:0], 1'b1, 1'b0, $sformatf("shift%0d", s));
            check_eq($sformatf("shift%0d_result", s), {16'd0, result}, {16'd0, sh_exp[s]});
            check_eq($sformatf("shift%0d_ain", s), {16'd0, ain}, 32'd0);
        end

        // Wrap-around with cmd_valid held through the busy cycles
        load_imm(3'd5, 16'hFFFF, "imm_r5");
        load_imm(3'd6, 16'h0001, "imm_r6");
        accepts   = 0;
        done_seen = 0;
        @(negedge clk);
        cmd_imm   = 1'b0;
        cmd_op    = 2'd0;
        cmd_rd    = 3'd7;
        cmd_rn    = 3'd5;
        cmd_rm    = 3'd6;
        cmd_shift = 2'b00;
        cmd_asel  = 1'b0;
        cmd_wb    = 1'b1;
        cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (cmd_ready) accepts++;
            @(posedge clk);
            #1;
            if (done) done_seen++;
            if (i < 4) @(negedge clk);
        end
        check_eq("wrap_accepts", accepts, 32'd1);
        check_eq("wrap_done_once", done_seen, 32'd1);
        check_eq("wrap_done_now", {31'd0, done}, 32'd1);
        check_eq("wrap_result", {16'd0, result}, 32'd0);
        check_eq("wrap_z", {31'd0, status_z}, 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        read_reg(3'd7, 16'h0000, "rd_r7");

        // Reset during EXEC abandons the write-back
        load_imm(3'd6, 16'd2, "imm_r6b");
        @(negedge clk);
        cmd_imm   = 1'b0;
        cmd_op    = 2'd0;
        cmd_rd    = 3'd5;
        cmd_rn    = 3'd0;
        cmd_rm    = 3'd6;
        cmd_asel  = 1'b0;
        cmd_wb    = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check_eq("mid_ain", {16'd0, ain}, 32'd5);
        reset_n = 1'b0;
        #1;
        check_eq("mid_rst_ready", {31'd0, cmd_ready}, 32'd0);
        check_eq("mid_rst_ain", {16'd0, ain}, 32'd0);
        check_eq("mid_rst_bin", {16'd0, bin}, 32'd0);
        check_eq("mid_rst_op", {30'd0, ALUop}, 32'd0);
        check_eq("mid_rst_result", {16'd0, result}, 32'd0);
        check_eq("mid_rst_z", {31'd0, status_z}, 32'd0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        check_eq("mid_rst_no_done", done_seen, 32'd0);
        check_eq("mid_rst_ready_after", {31'd0, cmd_ready}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            read_reg(i[2:0], 16'd0, $sformatf("rst_r%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
